// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the multiply/divide unit state type.
package mips_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: one bit per cycle on
// operand magnitudes, sign correction applied in a final FIX cycle.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    muldiv_state_t      state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               negq_q, negq_d, negr_q, negr_d;
    logic               zdiv_q, zdiv_d;
    logic               done_q, done_d, div_zero_q, div_zero_d;

    logic               signed_op_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic [WIDTH:0]     mul_sum_s, rem_sh_s, div_diff_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quot_fix_s, rem_fix_s;

    assign signed_op_s = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    assign a_mag_s     = (signed_op_s && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
    assign b_mag_s     = (signed_op_s && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;

    assign mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                       + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    // Remainder stays below the divisor, so bit WIDTH of the difference is a clean borrow.
    assign rem_sh_s    = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff_s  = rem_sh_s - {1'b0, opb_q};

    assign prod_fix_s  = negq_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
    assign quot_fix_s  = negq_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    assign rem_fix_s   = negr_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

    // Next-state and datapath update for issue, iteration and sign fix-up.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        zdiv_d     = zdiv_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (funct)
                        FUNCT_MTHI: hi_d = a;
                        FUNCT_MTLO: lo_d = a;
                        FUNCT_MULT, FUNCT_MULTU: begin
                            state_d  = ST_MUL;
                            cnt_d    = CW'(WIDTH);
                            acc_d    = {{WIDTH{1'b0}}, b_mag_s};
                            opb_d    = a_mag_s;
                            is_div_d = 1'b0;
                            negq_d   = signed_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                            negr_d   = signed_op_s & a[WIDTH-1];
                            zdiv_d   = 1'b0;
                        end
                        FUNCT_DIV, FUNCT_DIVU: begin
                            state_d  = ST_DIV;
                            cnt_d    = CW'(WIDTH);
                            acc_d    = {{WIDTH{1'b0}}, a_mag_s};
                            opb_d    = b_mag_s;
                            is_div_d = 1'b1;
                            negq_d   = signed_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                            negr_d   = signed_op_s & a[WIDTH-1];
                            zdiv_d   = (b == {WIDTH{1'b0}});
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = ST_FIX;
                else                 state_d = ST_MUL;
            end
            ST_DIV: begin
                if (!div_diff_s[WIDTH]) acc_d = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else                    acc_d = {rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = ST_FIX;
                else                 state_d = ST_DIV;
            end
            ST_FIX: begin
                // Divide by zero yields all-ones quotient; remainder path already restores a.
                if (is_div_q) begin
                    lo_d       = zdiv_q ? {WIDTH{1'b1}} : quot_fix_s;
                    hi_d       = rem_fix_s;
                    div_zero_d = zdiv_q;
                end else begin
                    {hi_d, lo_d} = prod_fix_s;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CW{1'b0}};
            acc_q      <= {(2*WIDTH){1'b0}};
            opb_q      <= {WIDTH{1'b0}};
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            is_div_q   <= 1'b0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            zdiv_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            negq_q     <= negq_d;
            negr_q     <= negr_d;
            zdiv_q     <= zdiv_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit (WIDTH=32 and WIDTH=8 builds)
// against an arithmetic reference model.
module tb_muldiv_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'd0;
    logic [31:0] a = 32'd0, b = 32'd0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0;
    logic [5:0]  funct8 = 6'd0;
    logic [7:0]  a8 = 8'd0, b8 = 8'd0;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(rst_n), .start(start), .funct(funct), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst_n), .start(start8), .funct(funct8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ez);
        longint sa, sb;
        logic [63:0] p, q, r;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        eh = 32'd0; el = 32'd0; ez = 1'b0;
        case (f)
            FUNCT_MULT:  begin p = 64'(sa * sb); {eh, el} = p; end
            FUNCT_MULTU: begin p = {32'd0, av} * {32'd0, bv}; {eh, el} = p; end
            FUNCT_DIV: begin
                if (bv == 32'd0) begin el = 32'hFFFF_FFFF; eh = av; ez = 1'b1; end
                else begin q = 64'(sa / sb); r = 64'(sa % sb); el = q[31:0]; eh = r[31:0]; end
            end
            FUNCT_DIVU: begin
                if (bv == 32'd0) begin el = 32'hFFFF_FFFF; eh = av; ez = 1'b1; end
                else begin el = av / bv; eh = av % bv; end
            end
            default: begin eh = 32'd0; el = 32'd0; end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Issue at the current negedge, track every cycle until done; returns in the done cycle.
    task automatic run_op(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                          input int inject_cyc, input string tag);
        logic [31:0] eh, el;
        logic ez;
        int cyc;
        bit got;
        model(f, av, bv, eh, el, ez);
        start = 1'b1; funct = f; a = av; b = bv;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_c0 got=%b exp=0", tag, busy); end
        cyc = 0; got = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == inject_cyc) begin start = 1'b1; funct = FUNCT_MTLO; a = $urandom; end
            else start = 1'b0;
            if (done === 1'b1) got = 1;
            else begin
                checks++;
                if (busy !== 1'b1 || div_zero !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_cyc%0d got busy=%b dz=%b exp busy=1 dz=0", tag, cyc, busy, div_zero);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (!got) begin errors++; $display("FAIL %s timeout got no done exp done by cycle 34", tag); end
        else begin
            checks++;
            if (cyc != 34 || busy !== 1'b0) begin
                errors++; $display("FAIL %s latency got cyc=%0d busy=%b exp cyc=34 busy=0", tag, cyc, busy);
            end
            checks++;
            if (hi !== eh || lo !== el || div_zero !== ez) begin
                errors++;
                $display("FAIL %s result got hi=%h lo=%h dz=%b exp hi=%h lo=%h dz=%b", tag, hi, lo, div_zero, eh, el, ez);
            end
        end
    endtask

    task automatic check_done_drop(input string tag);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || div_zero !== 1'b0) begin
            errors++; $display("FAIL %s done_drop got done=%b dz=%b exp 0 0", tag, done, div_zero);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset32 got busy=%b done=%b dz=%b hi=%h lo=%h exp all 0", busy, done, div_zero, hi, lo);
        end
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || hi8 !== 8'd0 || lo8 !== 8'd0) begin
            errors++; $display("FAIL reset8 got busy=%b done=%b hi=%h lo=%h exp all 0", busy8, done8, hi8, lo8);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_move();
        start = 1'b1; funct = FUNCT_MTHI; a = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (hi !== 32'h0000_1234 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mthi got hi=%h busy=%b done=%b exp hi=00001234 busy=0 done=0", hi, busy, done);
        end
        start = 1'b1; funct = FUNCT_MTLO; a = 32'h0000_5678;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (lo !== 32'h0000_5678 || hi !== 32'h0000_1234 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mtlo got hi=%h lo=%h busy=%b done=%b exp 00001234 00005678 0 0", hi, lo, busy, done);
        end
        start = 1'b1; funct = FUNCT_MFHI; a = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (lo !== 32'h0000_5678 || hi !== 32'h0000_1234 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL bad_funct got hi=%h lo=%h busy=%b done=%b exp unchanged idle", hi, lo, busy, done);
        end
    endtask

    task automatic test_directed();
        logic [5:0]  tf [7] = '{FUNCT_MULTU, FUNCT_MULT, FUNCT_MULT, FUNCT_DIV, FUNCT_DIVU, FUNCT_DIV, FUNCT_DIVU};
        logic [31:0] ta [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd5};
        logic [31:0] tb [7] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] th [7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd5};
        logic [31:0] tl [7] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'd0, 32'hFFFF_FFFD, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 7; i++) begin
            run_op(tf[i], ta[i], tb[i], 0, $sformatf("directed%0d", i));
            checks++;
            if (hi !== th[i] || lo !== tl[i]) begin
                errors++; $display("FAIL directed%0d_plan got hi=%h lo=%h exp hi=%h lo=%h", i, hi, lo, th[i], tl[i]);
            end
            check_done_drop($sformatf("directed%0d", i));
        end
    endtask

    task automatic test_busy_ignore();
        run_op(FUNCT_MULT, 32'hFFFF_FF00, 32'h0001_2345, 10, "busy_ignore");
        check_done_drop("busy_ignore");
    endtask

    task automatic test_back_to_back();
        run_op(FUNCT_DIVU, 32'd1000, 32'd33, 0, "b2b0");
        run_op(FUNCT_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 0, "b2b1");
        run_op(FUNCT_DIV, 32'h8000_0000, 32'd0, 0, "b2b2");
        check_done_drop("b2b2");
    endtask

    task automatic test_random();
        logic [5:0] fs [4] = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
        for (int i = 0; i < 24; i++)
            run_op(fs[$urandom_range(0, 3)], pick_operand(), pick_operand(), 0, $sformatf("rand%0d", i));
        check_done_drop("rand_end");
    endtask

    task automatic test_width8();
        logic [7:0] av, bv, eh, el;
        logic ez, is_mul;
        int cyc;
        bit got;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin av = 8'd200; bv = 8'd7; is_mul = 1'b0; end
            else begin av = 8'($urandom); bv = (i == 1) ? 8'd0 : 8'($urandom); is_mul = (i > 3); end
            ez = 1'b0;
            if (is_mul) {eh, el} = {8'd0, av} * {8'd0, bv};
            else if (bv == 8'd0) begin el = 8'hFF; eh = av; ez = 1'b1; end
            else begin el = av / bv; eh = av % bv; end
            start8 = 1'b1; funct8 = is_mul ? FUNCT_MULTU : FUNCT_DIVU; a8 = av; b8 = bv;
            cyc = 0; got = 0;
            while (!got && cyc < 20) begin
                @(negedge clk);
                start8 = 1'b0;
                cyc++;
                if (done8 === 1'b1) got = 1;
            end
            checks++;
            if (!got || cyc != 10) begin
                errors++; $display("FAIL w8_%0d latency got cyc=%0d done=%b exp cyc=10", i, cyc, got);
            end
            checks++;
            if (hi8 !== eh || lo8 !== el || dz8 !== ez) begin
                errors++;
                $display("FAIL w8_%0d result got hi=%h lo=%h dz=%b exp hi=%h lo=%h dz=%b", i, hi8, lo8, dz8, eh, el, ez);
            end
            if (i == 0) begin
                checks++;
                if (lo8 !== 8'd28 || hi8 !== 8'd4) begin
                    errors++; $display("FAIL w8_plan got hi=%0d lo=%0d exp hi=4 lo=28", hi8, lo8);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        bit saw_done;
        start = 1'b1; funct = FUNCT_MTHI; a = 32'hDEAD_0001;
        @(negedge clk);
        funct = FUNCT_MTLO; a = 32'hBEEF_0002;
        @(negedge clk);
        funct = FUNCT_DIV; a = 32'h1234_5678; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL reset_midop got busy=%b hi=%h lo=%h exp 0 0 0", busy, hi, lo);
        end
        saw_done = 0;
        repeat (3) begin @(negedge clk); if (done === 1'b1) saw_done = 1; end
        rst_n = 1'b1;
        repeat (30) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) saw_done = 1; end
        checks++;
        if (saw_done) begin errors++; $display("FAIL reset_abort got done/busy after reset exp none"); end
        run_op(FUNCT_MULTU, 32'd6, 32'd7, 0, "post_reset");
        checks++;
        if (lo !== 32'd42 || hi !== 32'd0) begin
            errors++; $display("FAIL post_reset_plan got hi=%h lo=%0d exp hi=0 lo=42", hi, lo);
        end
        check_done_drop("post_reset");
    endtask

    initial begin
        test_reset();
        test_move();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_width8();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
